// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit
//   Owns the program counter, holds each fetch address for WAIT_CYCLES extra
//   cycles while the instruction memory settles, captures the word into an
//   output register and hands it to decode over a valid/ready handshake.
//   Taken branches from execute redirect the pc and squash wrong-path work.
//
// Ports
//   CLK, Reset_L        clock (rising edge), async active-low reset
//   startPC             first fetch address, sampled on the first edge out of reset
//   imem_addr/imem_data instruction memory address (== pc) / combinational read data
//   redirect/redirect_pc taken-branch request and target
//   instr/instr_pc      captured instruction and the address it came from
//   instr_valid/ready   handshake with decode
module instr_fetch_unit #(
    parameter int          WAIT_CYCLES = 1,
    parameter logic [63:0] PC_INC      = 64'd4
) (
    input  logic        CLK,
    input  logic        Reset_L,
    input  logic [63:0] startPC,
    output logic [63:0] imem_addr,
    input  logic [31:0] imem_data,
    input  logic        redirect,
    input  logic [63:0] redirect_pc,
    output logic [31:0] instr,
    output logic [63:0] instr_pc,
    output logic        instr_valid,
    input  logic        instr_ready
);

    typedef enum logic [1:0] {S_BOOT, S_FETCH, S_STALL} state_t;

    localparam logic [3:0] WAIT_TERM = 4'(WAIT_CYCLES);

    state_t      state_q, state_d;
    logic [63:0] pc_q, pc_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] instr_q, instr_d;
    logic [63:0] ipc_q, ipc_d;
    logic        valid_q, valid_d;

    logic terminal, xfer, slot_free, capture;

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        cnt_d     = cnt_q;
        instr_d   = instr_q;
        ipc_d     = ipc_q;
        valid_d   = valid_q;
        capture   = 1'b0;
        terminal  = (cnt_q == WAIT_TERM);
        xfer      = valid_q & instr_ready;
        // The output register can take a new word if it is empty or is
        // being emptied by decode on this very edge.
        slot_free = ~valid_q | xfer;

        if (state_q == S_BOOT) begin
            pc_d    = redirect ? redirect_pc : startPC;
            cnt_d   = 4'd0;
            state_d = S_FETCH;
        end else if (redirect) begin
            // Squash: the in-flight fetch and any undelivered instruction are
            // dropped. A transfer on this edge has already been seen by decode.
            pc_d    = redirect_pc;
            cnt_d   = 4'd0;
            valid_d = 1'b0;
            state_d = S_FETCH;
        end else begin
            case (state_q)
                S_FETCH: begin
                    if (terminal) begin
                        if (slot_free) capture = 1'b1;
                        else           state_d = S_STALL;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                        if (xfer) valid_d = 1'b0;
                    end
                end
                S_STALL: begin
                    // Counter is parked at terminal, so the memory word is
                    // already settled; refill on the same edge decode drains.
                    if (instr_ready) begin
                        capture = 1'b1;
                        state_d = S_FETCH;
                    end
                end
                default: state_d = S_BOOT;
            endcase
        end

        if (capture) begin
            instr_d = imem_data;
            ipc_d   = pc_q;
            valid_d = 1'b1;
            pc_d    = pc_q + PC_INC;
            cnt_d   = 4'd0;
        end
    end

    always_ff @(posedge CLK or negedge Reset_L) begin
        if (!Reset_L) begin
            state_q <= S_BOOT;
            pc_q    <= 64'd0;
            cnt_q   <= 4'd0;
            instr_q <= 32'd0;
            ipc_q   <= 64'd0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
            instr_q <= instr_d;
            ipc_q   <= ipc_d;
            valid_q <= valid_d;
        end
    end

    assign imem_addr   = pc_q;
    assign instr       = instr_q;
    assign instr_pc    = ipc_q;
    assign instr_valid = valid_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    // u0: WAIT_CYCLES=1, main DUT
    logic        rst0_n, rdy0, redir0;
    logic [63:0] start0, rpc0, addr0, ipc0;
    logic [31:0] data0, instr0;
    logic        v0;
    // u1: WAIT_CYCLES=0, pc wrap / full-rate test
    logic        rst1_n, rdy1, redir1;
    logic [63:0] start1, rpc1, addr1, ipc1;
    logic [31:0] data1, instr1;
    logic        v1;

    int n_cmp = 0;
    int n_bad = 0;

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        logic [31:0] w;
        case (a)
            64'h00: w = 32'hF84003E9;
            64'h04: w = 32'hF84083EA;
            64'h08: w = 32'hF84103EB;
            64'h0C: w = 32'hF84183EC;
            64'h10: w = 32'h8B0A012A;
            64'h14: w = 32'hAA0B014A;
            64'h18: w = 32'h8A0A018C;
            64'h1C: w = 32'hCB0A016C;
            64'h34: w = 32'hB2048FE9;
            default: w = (a[31:0] * 32'h9E3779B1) ^ a[63:32] ^ 32'hC3C33C3C;
        endcase
        return w;
    endfunction

    assign data0 = mem_word(addr0);
    assign data1 = mem_word(addr1);

    instr_fetch_unit #(.WAIT_CYCLES(1), .PC_INC(64'd4)) u0 (
        .CLK(CLK), .Reset_L(rst0_n), .startPC(start0), .imem_addr(addr0),
        .imem_data(data0), .redirect(redir0), .redirect_pc(rpc0), .instr(instr0),
        .instr_pc(ipc0), .instr_valid(v0), .instr_ready(rdy0));

    instr_fetch_unit #(.WAIT_CYCLES(0), .PC_INC(64'd4)) u1 (
        .CLK(CLK), .Reset_L(rst1_n), .startPC(start1), .imem_addr(addr1),
        .imem_data(data1), .redirect(redir1), .redirect_pc(rpc1), .instr(instr1),
        .instr_pc(ipc1), .instr_valid(v1), .instr_ready(rdy1));

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic chk0(input string tag, input logic ev, input logic [31:0] ei,
                        input logic [63:0] eipc, input logic [63:0] eaddr);
        chk({tag, "_valid"}, 64'(v0), 64'(ev));
        chk({tag, "_instr"}, 64'(instr0), 64'(ei));
        chk({tag, "_ipc"},   ipc0, eipc);
        chk({tag, "_addr"},  addr0, eaddr);
    endtask

    task automatic step0(input logic r, input logic rd, input logic [63:0] t);
        rdy0 = r; redir0 = rd; rpc0 = t;
        @(posedge CLK); #1;
    endtask

    typedef struct {
        logic        rdy;
        logic        redir;
        logic [63:0] rpc;
        logic        ev;
        logic [31:0] ei;
        logic [63:0] eipc;
        logic [63:0] eaddr;
    } vec_t;

    function automatic vec_t mk(input logic r, input logic rd, input logic [63:0] t,
                                input logic ev, input logic [63:0] eipc, input logic [63:0] eaddr,
                                input logic have_word);
        vec_t x;
        x.rdy = r; x.redir = rd; x.rpc = t; x.ev = ev;
        x.ei = have_word ? mem_word(eipc) : 32'd0;
        x.eipc = eipc; x.eaddr = eaddr;
        return x;
    endfunction

    vec_t tv[31];

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [63:0] exp_next, pp;
        logic [31:0] pi;
        logic        pv, xfer, r, rd;
        logic [63:0] t;
        int          ndel;

        // Lab program, WAIT_CYCLES=1, startPC=0. Row k = edge k after release.
        tv[0]  = mk(1, 0, 0, 0, 64'h00, 64'h00, 0);
        tv[1]  = mk(1, 0, 0, 0, 64'h00, 64'h00, 0);
        tv[2]  = mk(1, 0, 0, 1, 64'h00, 64'h04, 1);
        tv[3]  = mk(1, 0, 0, 0, 64'h00, 64'h04, 1);
        tv[4]  = mk(1, 0, 0, 1, 64'h04, 64'h08, 1);
        tv[5]  = mk(1, 0, 0, 0, 64'h04, 64'h08, 1);
        tv[6]  = mk(1, 0, 0, 1, 64'h08, 64'h0C, 1);
        tv[7]  = mk(1, 0, 0, 0, 64'h08, 64'h0C, 1);
        tv[8]  = mk(1, 0, 0, 1, 64'h0C, 64'h10, 1);
        tv[9]  = mk(1, 0, 0, 0, 64'h0C, 64'h10, 1);
        tv[10] = mk(1, 0, 0, 1, 64'h10, 64'h14, 1);
        tv[11] = mk(1, 0, 0, 0, 64'h10, 64'h14, 1);
        tv[12] = mk(1, 0, 0, 1, 64'h14, 64'h18, 1);
        // backpressure: five edges with decode not ready
        tv[13] = mk(0, 0, 0, 1, 64'h14, 64'h18, 1);
        tv[14] = mk(0, 0, 0, 1, 64'h14, 64'h18, 1);
        tv[15] = mk(0, 0, 0, 1, 64'h14, 64'h18, 1);
        tv[16] = mk(0, 0, 0, 1, 64'h14, 64'h18, 1);
        tv[17] = mk(0, 0, 0, 1, 64'h14, 64'h18, 1);
        tv[18] = mk(1, 0, 0, 1, 64'h18, 64'h1C, 1);
        tv[19] = mk(1, 0, 0, 0, 64'h18, 64'h1C, 1);
        tv[20] = mk(1, 0, 0, 1, 64'h1C, 64'h20, 1);
        tv[21] = mk(1, 0, 0, 0, 64'h1C, 64'h20, 1);
        tv[22] = mk(1, 0, 0, 1, 64'h20, 64'h24, 1);
        tv[23] = mk(1, 0, 0, 0, 64'h20, 64'h24, 1);
        tv[24] = mk(1, 0, 0, 1, 64'h24, 64'h28, 1);
        tv[25] = mk(1, 0, 0, 0, 64'h24, 64'h28, 1);
        tv[26] = mk(1, 0, 0, 1, 64'h28, 64'h2C, 1);
        // redirect while fetching 0x2C back to 0x1C
        tv[27] = mk(1, 1, 64'h1C, 0, 64'h28, 64'h1C, 1);
        tv[28] = mk(1, 0, 0, 0, 64'h28, 64'h1C, 1);
        tv[29] = mk(1, 0, 0, 1, 64'h1C, 64'h20, 1);
        tv[30] = mk(1, 0, 0, 0, 64'h1C, 64'h20, 1);

        rst0_n = 0; start0 = 0; rdy0 = 1; redir0 = 0; rpc0 = 0;
        rst1_n = 0; start1 = 64'hFFFF_FFFF_FFFF_FFF8; rdy1 = 1; redir1 = 0; rpc1 = 0;
        #1;
        chk0("reset", 0, 32'd0, 64'd0, 64'd0);
        #11 rst0_n = 1;

        foreach (tv[i]) begin
            step0(tv[i].rdy, tv[i].redir, tv[i].rpc);
            chk0($sformatf("vec%0d", i + 1), tv[i].ev, tv[i].ei, tv[i].eipc, tv[i].eaddr);
        end

        // Redirect on the edge where a stalled fetch would otherwise refill.
        step0(1, 0, 0);  // capture 0x20
        step0(0, 0, 0);  // count
        step0(0, 0, 0);  // terminal, slot full -> stall
        chk0("stall_hold", 1, mem_word(64'h20), 64'h20, 64'h24);
        step0(0, 1, 64'h40);
        chk("stall_redir_valid", 64'(v0), 64'd0);
        chk("stall_redir_addr", addr0, 64'h40);
        step0(1, 0, 0);
        chk("stall_redir_gap", 64'(v0), 64'd0);
        step0(1, 0, 0);
        chk0("stall_redir_deliv", 1, mem_word(64'h40), 64'h40, 64'h44);

        // Reset asserted while stalled: outputs clear without a clock edge.
        step0(0, 0, 0);
        step0(0, 0, 0);
        chk("pre_reset_valid", 64'(v0), 64'd1);
        start0 = 64'h34;
        rst0_n = 0;
        #1;
        chk0("async_reset", 0, 32'd0, 64'd0, 64'd0);
        #3 rst0_n = 1;
        step0(1, 0, 0);
        step0(1, 0, 0);
        chk("restart_latency", 64'(v0), 64'd0);
        step0(1, 0, 0);
        chk0("restart_first", 1, 32'hB2048FE9, 64'h34, 64'h38);

        // WAIT_CYCLES=0 across the 64-bit wrap.
        rst1_n = 1;
        @(posedge CLK); #1;
        chk("wrap_boot_valid", 64'(v1), 64'd0);
        chk("wrap_boot_addr", addr1, 64'hFFFF_FFFF_FFFF_FFF8);
        begin
            logic [63:0] ep;
            ep = 64'hFFFF_FFFF_FFFF_FFF8;
            for (int k = 0; k < 4; k++) begin
                @(posedge CLK); #1;
                chk($sformatf("wrap%0d_valid", k), 64'(v1), 64'd1);
                chk($sformatf("wrap%0d_ipc", k), ipc1, ep);
                chk($sformatf("wrap%0d_instr", k), 64'(instr1), 64'(mem_word(ep)));
                ep = ep + 64'd4;
                chk($sformatf("wrap%0d_addr", k), addr1, ep);
            end
        end

        // Random ready/redirect against a delivered-stream model: each transfer
        // must carry the word stored at its pc, and pcs run sequentially from
        // the start address or the most recent redirect target.
        rst0_n = 0; start0 = 64'h0; rdy0 = 1; redir0 = 0;
        #3 rst0_n = 1;
        exp_next = 64'h0;
        ndel = 0;
        step0(1, 0, 0);  // boot edge
        for (int c = 0; c < 3000; c++) begin
            r  = ($urandom_range(0, 9) < 7);
            rd = ($urandom_range(0, 19) == 0);
            t  = 64'($urandom_range(0, 1023));
            if ($urandom_range(0, 3) != 0) t[1:0] = 2'b00;
            rdy0 = r; redir0 = rd; rpc0 = t;
            pv = v0; pi = instr0; pp = ipc0;
            xfer = pv & r;
            @(posedge CLK); #1;
            if (xfer) begin
                chk("rnd_pc", pp, exp_next);
                chk("rnd_word", 64'(pi), 64'(mem_word(pp)));
                ndel++;
                exp_next = pp + 64'd4;
            end
            if (rd) begin
                exp_next = t;
                chk("rnd_redir_valid", 64'(v0), 64'd0);
                chk("rnd_redir_addr", addr0, t);
            end
        end
        chk("rnd_delivery_count", 64'(ndel >= 300), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Owns the program counter and drives the address input of the instruction memory.
- Waits a programmable number of cycles for the memory word to settle, then captures it into an output instruction register.
- Presents the captured instruction to decode with a valid/ready handshake.
- Accepts branch redirects from execute (CBZ taken, B) and discards wrong-path fetches.

Parameters:
- WAIT_CYCLES, 1, extra cycles each fetch address is held before the memory word is sampled (covers memory read time); legal range 0..15.
- PC_INC, 4, byte increment between sequential fetches.

Ports:
- CLK  input  1  system clock, rising edge.
- Reset_L  input  1  asynchronous active-low reset.
- startPC  input  64  first fetch address; sampled on the first rising edge after Reset_L deasserts.
- imem_addr  output  64  address to instruction memory; equals the pc register.
- imem_data  input  32  instruction word returned by memory (combinational read).
- redirect  input  1  taken branch; wins over every event except reset.
- redirect_pc  input  64  branch target, sampled when redirect=1.
- instr  output  32  captured instruction.
- instr_pc  output  64  address instr was fetched from.
- instr_valid  output  1  instr/instr_pc hold a valid, undelivered instruction.
- instr_ready  input  1  decode accepts; transfer occurs when instr_valid & instr_ready.

Behaviour:
- Reset (async, Reset_L=0):
  - pc=0, instr=0, instr_pc=0, instr_valid=0, wait counter=0, state=BOOT.
  - Reset asserted mid-fetch or mid-hold aborts everything immediately.
- BOOT: on the first rising edge with Reset_L=1, pc<=startPC, counter<=0, state<=FETCH. instr_valid stays 0. If redirect=1 on that same edge, redirect_pc is used instead of startPC.
- FETCH:
  - imem_addr=pc is held stable.
  - On each edge with counter<WAIT_CYCLES: counter++.
  - On an edge with counter==WAIT_CYCLES (terminal), capture is allowed if the slot is free: instr_valid=0, or instr_valid & instr_ready this cycle. When capture is allowed:
    - instr<=imem_data, instr_pc<=pc, instr_valid<=1.
    - pc<=pc+PC_INC (64-bit, wraps modulo 2^64), counter<=0.
  - Terminal count with the slot not free: state<=STALL; pc and counter hold.
- STALL:
  - imem_addr still =pc.
  - When instr_ready=1: the held instruction is consumed. On the same edge the new word is captured as in the FETCH capture case (one cycle after stall-release, no bubble), and state<=FETCH.
- Drain without refill: transfer while the counter is not terminal sets instr_valid<=0.
- Throughput:
  - Steady state is one instruction per WAIT_CYCLES+1 cycles.
  - WAIT_CYCLES=0 with instr_ready held high gives one instruction per cycle.
- Redirect (any state except BOOT handled above):
  - pc<=redirect_pc, counter<=0, state<=FETCH, instr_valid<=0, whether or not decode is accepting.
  - The in-flight fetch is discarded and no capture occurs on that edge.
  - A transfer signalled on the redirect edge still counts as delivered to decode; the fetch unit does not retract it.
- Misaligned redirect_pc (low two bits ≠0) is fetched as given; no alignment fault is raised.
- instr and instr_pc hold their last values while instr_valid=0.
- Latency: first instr_valid=1 occurs WAIT_CYCLES+2 edges after reset release (1 BOOT + WAIT_CYCLES counting + 1 capture).

Test Plan:
- Reset release, startPC=0, WAIT_CYCLES=1, memory holds the lab program, instr_ready=1:
  - instr_valid first rises after edge 3 with instr=F84003E9, instr_pc=0.
  - Next deliveries every 2 cycles: F84083EA@4, F84103EB@8.
- Backpressure: instr_ready=0 for 5 cycles once instr=AA0B014A@14 is valid:
  - instr and instr_pc hold, and imem_addr holds 0x18.
  - On release, 8A0A018C@18 is valid the next edge; no instruction is skipped or duplicated.
- Redirect: while fetching 0x2C, pulse redirect=1 with redirect_pc=0x1C:
  - instr_valid=0 on the next edge; imem_addr=0x1C.
  - Next delivered instr is CB09018C? No — it is the word at 0x1C with instr_pc=0x1C; no word from 0x2C is delivered.
- Redirect coincident with a STALL terminal capture:
  - The held instruction is dropped unless instr_ready=1 on that edge.
  - The stalled word is never captured; pc=target.
- Reset mid-STALL (Reset_L low for half a cycle):
  - Outputs go to 0 immediately, without waiting for a clock edge.
  - Restart from startPC=0x34 delivers B2048FE9@34 first.
- WAIT_CYCLES=0, startPC=0xFFFFFFFFFFFFFFF8: pc wraps to 0 after 0xFFFFFFFFFFFFFFFC, with one instruction per cycle.
